// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the data-memory bridge: control-bit layout,
// access size codes, bridge FSM encoding and the default access timeout.
package cpu_pkg;

    localparam int CTL_LOAD           = 3;
    localparam int CTL_STORE          = 2;
    localparam int DM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } dm_state_e;

    // Halfwords must sit on even addresses and words on 4-byte boundaries.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: byte enables and write shifting for the outgoing
// access, and byte/half extraction from the captured read word.
module dm_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  wr_off,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_size,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [31:0] wr_mask;
    logic [31:0] rd_mask;

    always_comb begin
        be      = 4'b1111;
        wr_mask = 32'hFFFF_FFFF;
        case (wr_size)
            SIZE_BYTE: begin
                be      = 4'b0001 << wr_off;
                wr_mask = 32'h0000_00FF;
            end
            SIZE_HALF: begin
                be      = 4'b0011 << wr_off;
                wr_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        // Upper bits of a narrow store may be stale CPU data, so trim before shifting.
        wdata = (wr_data & wr_mask) << {wr_off, 3'b000};
    end

    always_comb begin
        rd_mask = 32'hFFFF_FFFF;
        case (rd_size)
            SIZE_BYTE: rd_mask = 32'h0000_00FF;
            SIZE_HALF: rd_mask = 32'h0000_FFFF;
            default:   ;
        endcase
        rd_data = (rd_word >> {rd_off, 3'b000}) & rd_mask;
    end

endmodule

// File: rtl/dm_bridge.sv
// Bridges the CPU MA-stage data access onto a req/gnt/rvalid memory port,
// stalling the CPU until the access completes, is rejected, or times out.
module dm_bridge #(
    parameter int TIMEOUT = cpu_pkg::DM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_store,
    input  logic [3:0]  dm_ctl,
    output logic [31:0] dm_load,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        misalign_err,
    output logic        bus_err
);

    import cpu_pkg::*;

    dm_state_e   state;
    dm_state_e   state_next;
    logic [7:0]  tmo_cnt;
    logic [31:0] data_reg;
    logic [1:0]  off_reg;
    logic [1:0]  size_reg;
    logic        is_load;
    logic        is_store;
    logic [1:0]  req_size;
    logic        pending;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    assign is_load     = dm_ctl[CTL_LOAD];
    assign is_store    = dm_ctl[CTL_STORE];
    assign req_size    = dm_ctl[1:0];
    assign pending     = (is_load ^ is_store) && (req_size != SIZE_RSVD);
    assign misaligned  = is_misaligned(req_size, dm_addr[1:0]);
    assign timeout_hit = (tmo_cnt == 8'(TIMEOUT - 1));
    assign mem_req     = (state == ST_REQ);

    dm_lane_align u_lane (
        .wr_off  (dm_addr[1:0]),
        .wr_size (req_size),
        .wr_data (dm_store),
        .be      (lane_be),
        .wdata   (lane_wdata),
        .rd_off  (off_reg),
        .rd_size (size_reg),
        .rd_word (data_reg),
        .rd_data (dm_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dm_ack     = 1'b0;
        case (state)
            ST_IDLE: begin
                dm_ack = !pending;
                if (pending) begin
                    state_next = misaligned ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_next = mem_we ? ST_DONE : ST_WAIT;
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                dm_ack     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Aborted and rejected accesses clear the data register so the CPU sees zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we       <= 1'b0;
            mem_be       <= 4'b0000;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            data_reg     <= 32'h0;
            off_reg      <= 2'b00;
            size_reg     <= SIZE_BYTE;
            tmo_cnt      <= 8'h00;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending && misaligned) begin
                        misalign_err <= 1'b1;
                        data_reg     <= 32'h0;
                    end else if (pending) begin
                        mem_we    <= is_store;
                        mem_be    <= lane_be;
                        mem_addr  <= {dm_addr[31:2], 2'b00};
                        mem_wdata <= lane_wdata;
                        off_reg   <= dm_addr[1:0];
                        size_reg  <= req_size;
                        tmo_cnt   <= 8'h00;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        tmo_cnt <= 8'h00;
                    end else if (timeout_hit) begin
                        bus_err  <= 1'b1;
                        data_reg <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        data_reg <= mem_rdata;
                    end else if (timeout_hit) begin
                        bus_err  <= 1'b1;
                        data_reg <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bridge.sv
// Directed checks of dm_bridge: stores, loads, lane steering, misalignment,
// timeout abort and asynchronous reset in the middle of an access.
module tb_dm_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] dm_addr;
    logic [31:0] dm_store;
    logic [3:0]  dm_ctl;
    logic [31:0] dm_load;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        misalign_err;
    logic        bus_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    dm_bridge #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dm_addr      (dm_addr),
        .dm_store     (dm_store),
        .dm_ctl       (dm_ctl),
        .dm_load      (dm_load),
        .dm_ack       (dm_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [3:0] ctl, input logic [31:0] addr,
                                  input logic [31:0] store, input logic gnt,
                                  input logic rvalid, input logic [31:0] rdata);
        dm_ctl     = ctl;
        dm_addr    = addr;
        dm_store   = store;
        mem_gnt    = gnt;
        mem_rvalid = rvalid;
        mem_rdata  = rdata;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected)
        else begin
            bad_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_output("rst_mem_req", 32'(mem_req), 32'h0);
        check_output("rst_mem_we", 32'(mem_we), 32'h0);
        check_output("rst_mem_be", 32'(mem_be), 32'h0);
        check_output("rst_mem_addr", mem_addr, 32'h0);
        check_output("rst_mem_wdata", mem_wdata, 32'h0);
        check_output("rst_dm_load", dm_load, 32'h0);
        check_output("rst_errs", {30'h0, misalign_err, bus_err}, 32'h0);
        check_output("rst_ack_idle", 32'(dm_ack), 32'h1);
        rst = 1'b1;

        // Illegal control encodings are not accesses
        apply_stimulus(4'b1100, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        check_output("nop_both_ack", 32'(dm_ack), 32'h1);
        apply_stimulus(4'b0111, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        check_output("nop_rsvd_ack", 32'(dm_ack), 32'h1);
        next_cycle();
        check_output("nop_no_req", 32'(mem_req), 32'h0);

        // Word store 0x100, grant in the first REQ cycle
        apply_stimulus(4'b0110, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        check_output("sw_ack_c1", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("sw_req", 32'(mem_req), 32'h1);
        check_output("sw_we", 32'(mem_we), 32'h1);
        check_output("sw_be", 32'(mem_be), 32'hF);
        check_output("sw_addr", mem_addr, 32'h100);
        check_output("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("sw_ack_c2", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("sw_ack_c3", 32'(dm_ack), 32'h1);
        check_output("sw_req_done", 32'(mem_req), 32'h0);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_output("sw_idle_ack", 32'(dm_ack), 32'h1);

        // Byte load 0x203; early rvalid during REQ must be ignored
        apply_stimulus(4'b1000, 32'h203, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
        check_output("lb_ack_c1", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("lb_req", 32'(mem_req), 32'h1);
        check_output("lb_be", 32'(mem_be), 32'h8);
        check_output("lb_addr", mem_addr, 32'h200);
        check_output("lb_we", 32'(mem_we), 32'h0);
        check_output("lb_ack_c2", 32'(dm_ack), 32'h0);
        next_cycle();
        apply_stimulus(4'b1000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11223344);
        check_output("lb_wait_req", 32'(mem_req), 32'h0);
        check_output("lb_ack_c3", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("lb_ack_c4", 32'(dm_ack), 32'h1);
        check_output("lb_load", dm_load, 32'h00000011);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Half store 0x102, grant one cycle late; request must hold steady
        next_cycle();
        apply_stimulus(4'b0101, 32'h102, 32'h0000ABCD, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_output("sh_be", 32'(mem_be), 32'hC);
        check_output("sh_wdata", mem_wdata, 32'hABCD0000);
        next_cycle();
        apply_stimulus(4'b0101, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        check_output("sh_hold_req", 32'(mem_req), 32'h1);
        check_output("sh_hold_addr", mem_addr, 32'h100);
        check_output("sh_hold_wdata", mem_wdata, 32'hABCD0000);
        check_output("sh_hold_ack", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("sh_ack", 32'(dm_ack), 32'h1);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Half load 0x102
        next_cycle();
        apply_stimulus(4'b1001, 32'h102, 32'h0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        check_output("lh_be", 32'(mem_be), 32'hC);
        next_cycle();
        apply_stimulus(4'b1001, 32'h102, 32'h0, 1'b0, 1'b1, 32'hCAFEBABE);
        next_cycle();
        check_output("lh_ack", 32'(dm_ack), 32'h1);
        check_output("lh_load", dm_load, 32'h0000CAFE);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Misaligned word load 0x101
        next_cycle();
        apply_stimulus(4'b1010, 32'h101, 32'h0, 1'b1, 1'b0, 32'h0);
        check_output("mis_ack_c1", 32'(dm_ack), 32'h0);
        next_cycle();
        check_output("mis_no_req", 32'(mem_req), 32'h0);
        check_output("mis_ack_c2", 32'(dm_ack), 32'h1);
        check_output("mis_err", 32'(misalign_err), 32'h1);
        check_output("mis_load", dm_load, 32'h0);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        check_output("mis_sticky", 32'(misalign_err), 32'h1);

        // Word load with no grant: abort after TIMEOUT=4 REQ cycles
        apply_stimulus(4'b1010, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            check_output($sformatf("tmo_req_c%0d", i), 32'(mem_req), 32'h1);
            check_output($sformatf("tmo_ack_c%0d", i), 32'(dm_ack), 32'h0);
        end
        check_output("tmo_buserr_pre", 32'(bus_err), 32'h0);
        next_cycle();
        check_output("tmo_req_drop", 32'(mem_req), 32'h0);
        check_output("tmo_ack", 32'(dm_ack), 32'h1);
        check_output("tmo_buserr", 32'(bus_err), 32'h1);
        check_output("tmo_load", dm_load, 32'h0);
        apply_stimulus(4'b1010, 32'h400, 32'h0, 1'b1, 1'b0, 32'h0);
        next_cycle();
        check_output("tmo_single_pulse", 32'(dm_ack), 32'h0);

        // Reset asserted while waiting for read data
        next_cycle();
        check_output("rw_req", 32'(mem_req), 32'h1);
        check_output("rw_addr", mem_addr, 32'h400);
        next_cycle();
        check_output("rw_wait_req", 32'(mem_req), 32'h0);
        rst = 1'b0;
        #1;
        check_output("rw_rst_req", 32'(mem_req), 32'h0);
        check_output("rw_rst_we", 32'(mem_we), 32'h0);
        check_output("rw_rst_be", 32'(mem_be), 32'h0);
        check_output("rw_rst_addr", mem_addr, 32'h0);
        check_output("rw_rst_wdata", mem_wdata, 32'h0);
        check_output("rw_rst_load", dm_load, 32'h0);
        check_output("rw_rst_errs", {30'h0, misalign_err, bus_err}, 32'h0);
        check_output("rw_rst_ack_pend", 32'(dm_ack), 32'h0);
        apply_stimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_output("rw_rst_ack_idle", 32'(dm_ack), 32'h1);
        rst = 1'b1;
        next_cycle();
        check_output("rw_post_req", 32'(mem_req), 32'h0);
        check_output("rw_post_ack", 32'(dm_ack), 32'h1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/dm_bridge.md
DM_BRIDGE -- requirements
Module: dm_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles spent in REQ or WAIT before an access is aborted.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 dm_addr  input  32  CPU MA-stage byte address.
REQ-005 dm_store  input  32  CPU store data, right-aligned (byte/half in low bits).
REQ-006 dm_ctl  input  4  access control: [3] load, [2] store, [1:0] size (00 byte, 01 half, 10 word, 11 reserved).
REQ-007 dm_load  output  32  load data, selected byte/half shifted to bit 0, zero-filled above; sign/trim done by CPU.
REQ-008 dm_ack  output  1  high = CPU may advance; low = stall MA.
REQ-009 mem_req  output  1  memory request valid.
REQ-010 mem_we  output  1  1 = write.
REQ-011 mem_be  output  4  byte-lane enables.
REQ-012 mem_addr  output  32  word address, bits [1:0] forced 00.
REQ-013 mem_wdata  output  32  lane-shifted write data.
REQ-014 mem_gnt  input  1  memory accepts request this cycle.
REQ-015 mem_rvalid  input  1  read data valid, at least one cycle after gnt.
REQ-016 mem_rdata  input  32  read word.
REQ-017 misalign_err  output  1  sticky, set on misaligned access.
REQ-018 bus_err  output  1  sticky, set on timeout.

Function
REQ-019 Access pending = exactly one of dm_ctl[3], dm_ctl[2] set and size != 11; anything else = no access, dm_ack stays 1.
REQ-020 FSM states IDLE, REQ, WAIT, DONE.
REQ-021 IDLE: dm_ack combinationally 0 when access pending; aligned access -> REQ next cycle; misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE, no memory traffic, misalign_err set.
REQ-022 REQ: mem_req=1, mem_addr/mem_we/mem_be/mem_wdata registered on IDLE exit and held stable until gnt.
REQ-023 REQ with gnt: store -> DONE; load -> WAIT.
REQ-024 WAIT: on rvalid capture mem_rdata into a data register -> DONE.
REQ-025 DONE: dm_ack=1 for exactly one cycle, dm_load valid from data register; -> IDLE unconditionally.
REQ-026 dm_ack=0 in REQ and WAIT.
REQ-027 mem_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-028 mem_wdata: store data replicated/shifted left 8*addr[1:0].
REQ-029 dm_load = data register >> 8*addr[1:0], masked to size; registered address offset used, not live dm_addr.
REQ-030 Minimum latency: store dm_ack low 2 cycles, high 3rd; load (gnt in REQ cycle 1, rvalid next) low 3 cycles, high 4th.
REQ-031 Timeout counter 8 bits, cleared on entry to REQ/WAIT, counts each cycle there; reaching TIMEOUT -> DONE, mem_req dropped, bus_err set, dm_load = 0.
REQ-032 mem_rvalid outside WAIT ignored; mem_gnt outside REQ ignored.
REQ-033 dm_ctl/dm_addr changes while in REQ/WAIT ignored (CPU is stalled).
REQ-034 Misaligned DONE returns dm_load = 0.

Reset
REQ-035 rst low: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, data register 0, counter 0, misalign_err=0, bus_err=0, immediately without clock.
REQ-036 Reset mid-access abandons it; memory must tolerate a dropped req; dm_ack reflects IDLE rules after release.

Structure
REQ-037 dm_ctl bit positions, size codes, FSM state encoding and default TIMEOUT live in shared package cpu_pkg.
REQ-038 One sub-module dm_lane_align: combinational byte-enable, write-shift and load-extract logic.

Verification
REQ-039 Word store addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle -> mem_be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF, dm_ack low 2 cycles, high 3rd.
REQ-040 Byte load addr 0x203, mem_rdata 0x11223344, rvalid 1 cycle after gnt -> dm_load=0x00000011, mem_be=1000, ack on 4th cycle.
REQ-041 Half store addr 0x102, data 0x0000ABCD -> mem_be=1100, mem_wdata[31:16]=0xABCD.
REQ-042 Word load addr 0x101 -> no mem_req, dm_ack on 2nd cycle, misalign_err=1, dm_load=0.
REQ-043 Load, gnt never asserted, TIMEOUT=4 -> mem_req drops after 4 cycles, bus_err=1, single dm_ack pulse.
REQ-044 rst low during WAIT -> all outputs reset same cycle, state IDLE, errors cleared.
